uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001: Parameter BAUD_DIV, default 5208, clk cycles per bit (50 MHz / 9600 baud); legal range 16..65535.
- REQ-002: Port clk, input, 1, the single system clock; every flop is on its rising edge.
- REQ-003: Port rst, input, 1, reset that is synchronous and active-high.
- REQ-004: Port RX, input, 1, asynchronous serial line, 8N1, idle high, LSB first.
- REQ-005: Port clr_rdy, input, 1, consumer acknowledge that clears rdy.
- REQ-006: Port rx_data, output, 8, last good received byte.
- REQ-007: Port rdy, output, 1, a valid byte is held in rx_data.
- REQ-008: Port frm_err, output, 1, one-cycle pulse when the stop bit samples low.
- REQ-009: Port ovr_err, output, 1, one-cycle pulse when a good byte completes while rdy=1 and clr_rdy=0.

Function
- REQ-010: RX shall pass through a two-flop synchronizer before any use; call the result rx_s.
- REQ-011: The state machine shall have the states IDLE, START, DATA and STOP.
- REQ-012: IDLE->START when rx_s=0; baud counter loaded with BAUD_DIV/2 (integer division).
- REQ-013: The baud counter shall count down every cycle outside IDLE; "tick" means count==0; each tick in START, DATA or STOP reloads BAUD_DIV-1.
- REQ-014: In START, a tick with rx_s=1 means a false start -> IDLE with no flags; a tick with rx_s=0 -> DATA with bit counter=0.
- REQ-015: In DATA, each tick shall shift rx_s into shift_reg[7], shifting right; after the 8th tick -> STOP.
- REQ-016: In STOP, a tick with rx_s=1 shall, next edge, load rx_data=shift_reg, set rdy=1, then -> IDLE.
- REQ-017: In STOP, a tick with rx_s=0 shall pulse frm_err for 1 cycle, leave rx_data and rdy unchanged, then -> IDLE.
- REQ-018: After a framing error, a new start shall be detected only once rx_s has returned to 1 (no re-trigger on a held-low line/break).
- REQ-019: Latency: rdy shall rise exactly 2 + BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles after the clk edge that first samples RX low.
- REQ-020: clr_rdy=1 shall clear rdy next edge; if a good byte completes in the same cycle, completion wins (rdy=1, new data).
- REQ-021: A good byte completing with rdy=1 and clr_rdy=0 shall overwrite rx_data, keep rdy=1 and pulse ovr_err.
- REQ-022: Back-to-back frames (next start edge immediately after the mid-stop sample) shall be received without loss.
- REQ-023: Counters shall be sized $clog2(BAUD_DIV) bits and 4 bits and shall never wrap below 0.

Reset
- REQ-024: On rst=1 at a clk edge: state=IDLE, synchronizer flops=1, rdy=0, frm_err=0, ovr_err=0, rx_data=8'h00, counters=0.
- REQ-025: rst asserted mid-frame shall abort the frame without flags; reception resumes at the first start after rst deasserts.

Structure
- REQ-026: Package uart_pkg shall hold the rx_state_t enum (IDLE, START, DATA, STOP) and the localparam DEFAULT_BAUD_DIV=5208.
- REQ-027: The baud down-counter shall be one sub-module, uart_baud_cnt (load value, load strobe, tick output), reusable by UART_tx; everything else stays inline.

Verification (BAUD_DIV=16; the bench drives RX from UART_tx at the same divisor)
- REQ-028: Send 8'hA5 -> rx_data=8'hA5 and rdy rises exactly 2+8+144+1=155 cycles after the RX fall.
- REQ-029: RX low pulse of 4 cycles -> no rdy, no frm_err, state back in IDLE; a following 8'h3C is received correctly.
- REQ-030: Frame 8'h55 with stop bit forced low -> one frm_err pulse, rdy stays 0, rx_data unchanged; a following 8'h0F is received correctly.
- REQ-031: Send 8'h11 then 8'h22 back-to-back with no clr_rdy -> rx_data=8'h22, rdy=1, exactly one ovr_err pulse.
- REQ-032: clr_rdy asserted on the cycle a byte completes -> rdy=1 and the new data is held; clr_rdy one cycle later -> rdy=0.
- REQ-033: rst pulsed at bit 4 of 8'hFF -> no flags; a subsequent 8'h81 is received with correct latency.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state type and default baud divisor
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    localparam int DEFAULT_BAUD_DIV = 5208;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, consumer acknowledge and received-byte status bundle
interface uart_rx_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr_err;
    modport master (output RX, clr_rdy, input rx_data, rdy, frm_err, ovr_err);
    modport slave  (input RX, clr_rdy, output rx_data, rdy, frm_err, ovr_err);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: loadable baud down-counter that saturates at zero and flags tick at zero
module uart_baud_cnt #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tick
);
    logic [WIDTH-1:0] r_cnt;
    // load has priority; otherwise count down while enabled, holding at zero
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en && r_cnt != '0)
            r_cnt <= r_cnt - WIDTH'(1);
    end
    assign o_tick = (r_cnt == '0);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with two-flop sync, mid-bit sampling, ready/overrun/framing flags
import uart_pkg::*;
module uart_rx #(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);
    localparam int W = $clog2(BAUD_DIV);
    localparam logic [W-1:0] HALF = W'(BAUD_DIV / 2);
    localparam logic [W-1:0] FULL = W'(BAUD_DIV - 1);

    rx_state_t    r_state;
    logic         r_sync1, r_rx_s, r_wait_high;
    logic         r_rdy, r_frm_err, r_ovr_err;
    logic [3:0]   r_bit_cnt;
    logic [7:0]   r_shift, r_rx_data;
    logic         w_tick, w_start, w_load, w_done, w_ferr, w_busy;
    logic [W-1:0] w_load_val;

    assign w_busy     = (r_state != IDLE);
    assign w_start    = !w_busy && !r_rx_s && !r_wait_high;
    assign w_load     = w_start || (w_busy && w_tick);
    assign w_load_val = w_start ? HALF : FULL;
    assign w_done     = (r_state == STOP) && w_tick && r_rx_s;
    assign w_ferr     = (r_state == STOP) && w_tick && !r_rx_s;

    uart_baud_cnt #(.WIDTH(W)) u_baud (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_busy),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tick     (w_tick)
    );

    // two-flop synchronizer for the asynchronous line, idling high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= bus.RX;
            r_rx_s  <= r_sync1;
        end
    end

    // frame sequencer: start validation, 8 data samples LSB first, stop check
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                IDLE:  if (w_start) r_state <= START;
                START: if (w_tick) begin
                    r_state   <= r_rx_s ? IDLE : DATA;
                    r_bit_cnt <= '0;
                end
                DATA:  if (w_tick) begin
                    r_shift   <= {r_rx_s, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) r_state <= STOP;
                end
                STOP:  if (w_tick) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // after a framing error, block new starts until the line has gone high again
    always_ff @(posedge clk) begin
        if (rst)
            r_wait_high <= 1'b0;
        else if (w_ferr)
            r_wait_high <= 1'b1;
        else if (r_rx_s)
            r_wait_high <= 1'b0;
    end

    // output holding register and flags; a completing byte beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data <= 8'h00;
            r_rdy     <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovr_err <= 1'b0;
        end else begin
            r_frm_err <= w_ferr;
            r_ovr_err <= w_done && r_rdy && !bus.clr_rdy;
            r_rdy     <= w_done || (r_rdy && !bus.clr_rdy);
            if (w_done) r_rx_data <= r_shift;
        end
    end

    assign bus.rx_data = r_rx_data;
    assign bus.rdy     = r_rdy;
    assign bus.frm_err = r_frm_err;
    assign bus.ovr_err = r_ovr_err;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx at BAUD_DIV=16
module tb_uart_rx;
    localparam int D   = 16;
    localparam int LAT = 2 + D / 2 + 9 * D + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int n_cmp = 0, n_fail = 0;
    int n_frm = 0, n_ovr = 0, n_rise = 0, rise_cyc = 0, fall_cyc = 0;
    int exp_frm = 0, exp_ovr = 0;
    logic prev_rdy = 1'b0;
    logic exp_rdy = 1'b0;
    logic [7:0] exp_data = 8'h00;

    uart_rx_if bus();
    uart_rx #(.BAUD_DIV(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // posedge counter used as the latency timebase
    always @(posedge clk) cyc <= cyc + 1;

    // event monitor: counts flag-high cycles and timestamps rdy rising edges
    always @(posedge clk) begin
        #1;
        if (bus.frm_err) n_frm++;
        if (bus.ovr_err) n_ovr++;
        if (bus.rdy && !prev_rdy) begin
            rise_cyc = cyc;
            n_rise++;
        end
        prev_rdy = bus.rdy;
    end

    // watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // behaves as a UART transmitter with the same divisor; entered and left on a negedge
    task automatic send_frame(input logic [7:0] d, input logic stop);
        bus.RX = 1'b0;
        fall_cyc = cyc + 1;
        wait_neg(D);
        for (int i = 0; i < 8; i++) begin
            bus.RX = d[i];
            wait_neg(D);
        end
        bus.RX = stop;
        wait_neg(D);
        bus.RX = 1'b1;
    endtask

    task automatic clear_rdy();
        bus.clr_rdy = 1'b1;
        wait_neg(1);
        bus.clr_rdy = 1'b0;
        exp_rdy = 1'b0;
    endtask

    // receiver reference: a good frame delivers its byte, a bad stop only flags
    task automatic model_frame(input logic [7:0] d, input logic stop, input logic clr_at_done);
        if (!stop) exp_frm++;
        else begin
            if (exp_rdy && !clr_at_done) exp_ovr++;
            exp_data = d;
            exp_rdy  = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_neg(3);
        n_cmp++; if (bus.rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", bus.rdy); end
        n_cmp++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", bus.rx_data); end
        n_cmp++; if (bus.frm_err !== 1'b0) begin n_fail++; $display("FAIL reset_frm: got %b expected 0", bus.frm_err); end
        n_cmp++; if (bus.ovr_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", bus.ovr_err); end
        rst = 1'b0;
        wait_neg(2);
    endtask

    task automatic test_basic;
        int r0;
        r0 = n_rise;
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1, 1'b0);
        wait_neg(2);
        n_cmp++; if (bus.rx_data !== exp_data) begin n_fail++; $display("FAIL basic_data: got %h expected %h", bus.rx_data, exp_data); end
        n_cmp++; if (bus.rdy !== exp_rdy) begin n_fail++; $display("FAIL basic_rdy: got %b expected %b", bus.rdy, exp_rdy); end
        n_cmp++; if (n_rise !== r0 + 1) begin n_fail++; $display("FAIL basic_rises: got %0d expected %0d", n_rise, r0 + 1); end
        n_cmp++; if (rise_cyc - fall_cyc !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", rise_cyc - fall_cyc, LAT); end
        n_cmp++; if (n_frm !== exp_frm) begin n_fail++; $display("FAIL basic_frm: got %0d expected %0d", n_frm, exp_frm); end
        clear_rdy();
        wait_neg(1);
        n_cmp++; if (bus.rdy !== 1'b0) begin n_fail++; $display("FAIL basic_clear: got %b expected 0", bus.rdy); end
    endtask

    task automatic test_false_start;
        int r0;
        r0 = n_rise;
        bus.RX = 1'b0;
        wait_neg(4);
        bus.RX = 1'b1;
        wait_neg(3 * D);
        n_cmp++; if (n_rise !== r0) begin n_fail++; $display("FAIL false_rises: got %0d expected %0d", n_rise, r0); end
        n_cmp++; if (n_frm !== exp_frm) begin n_fail++; $display("FAIL false_frm: got %0d expected %0d", n_frm, exp_frm); end
        n_cmp++; if (bus.rdy !== 1'b0) begin n_fail++; $display("FAIL false_rdy: got %b expected 0", bus.rdy); end
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1, 1'b0);
        wait_neg(2);
        n_cmp++; if (bus.rx_data !== exp_data) begin n_fail++; $display("FAIL false_next_data: got %h expected %h", bus.rx_data, exp_data); end
        n_cmp++; if (rise_cyc - fall_cyc !== LAT) begin n_fail++; $display("FAIL false_next_latency: got %0d expected %0d", rise_cyc - fall_cyc, LAT); end
        clear_rdy();
    endtask

    task automatic test_framing;
        send_frame(8'h55, 1'b0);
        model_frame(8'h55, 1'b0, 1'b0);
        wait_neg(3);
        n_cmp++; if (n_frm !== exp_frm) begin n_fail++; $display("FAIL frame_pulses: got %0d expected %0d", n_frm, exp_frm); end
        n_cmp++; if (bus.rdy !== 1'b0) begin n_fail++; $display("FAIL frame_rdy: got %b expected 0", bus.rdy); end
        n_cmp++; if (bus.rx_data !== exp_data) begin n_fail++; $display("FAIL frame_data_kept: got %h expected %h", bus.rx_data, exp_data); end
        send_frame(8'h0F, 1'b1);
        model_frame(8'h0F, 1'b1, 1'b0);
        wait_neg(2);
        n_cmp++; if (bus.rx_data !== exp_data) begin n_fail++; $display("FAIL frame_next_data: got %h expected %h", bus.rx_data, exp_data); end
        n_cmp++; if (bus.rdy !== exp_rdy) begin n_fail++; $display("FAIL frame_next_rdy: got %b expected %b", bus.rdy, exp_rdy); end
        clear_rdy();
    endtask

    task automatic test_break;
        int r0;
        r0 = n_rise;
        bus.RX = 1'b0;
        wait_neg(24 * D);
        bus.RX = 1'b1;
        wait_neg(D);
        exp_frm++;
        n_cmp++; if (n_frm !== exp_frm) begin n_fail++; $display("FAIL break_frm: got %0d expected %0d", n_frm, exp_frm); end
        n_cmp++; if (n_rise !== r0) begin n_fail++; $display("FAIL break_rises: got %0d expected %0d", n_rise, r0); end
        send_frame(8'h6B, 1'b1);
        model_frame(8'h6B, 1'b1, 1'b0);
        wait_neg(2);
        n_cmp++; if (bus.rx_data !== exp_data) begin n_fail++; $display("FAIL break_next_data: got %h expected %h", bus.rx_data, exp_data); end
        clear_rdy();
    endtask

    task automatic test_back_to_back;
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1);
        model_frame(8'h22, 1'b1, 1'b0);
        wait_neg(2);
        n_cmp++; if (bus.rx_data !== exp_data) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", bus.rx_data, exp_data); end
        n_cmp++; if (bus.rdy !== exp_rdy) begin n_fail++; $display("FAIL b2b_rdy: got %b expected %b", bus.rdy, exp_rdy); end
        n_cmp++; if (n_ovr !== exp_ovr) begin n_fail++; $display("FAIL b2b_ovr: got %0d expected %0d", n_ovr, exp_ovr); end
    endtask

    task automatic test_clr_collision;
        fork
            send_frame(8'h9A, 1'b1);
            begin
                wait_neg(LAT);
                bus.clr_rdy = 1'b1;
                wait_neg(1);
                model_frame(8'h9A, 1'b1, 1'b1);
                n_cmp++; if (bus.rdy !== exp_rdy) begin n_fail++; $display("FAIL coll_rdy: got %b expected %b", bus.rdy, exp_rdy); end
                n_cmp++; if (bus.rx_data !== exp_data) begin n_fail++; $display("FAIL coll_data: got %h expected %h", bus.rx_data, exp_data); end
                wait_neg(1);
                bus.clr_rdy = 1'b0;
                exp_rdy = 1'b0;
                n_cmp++; if (bus.rdy !== exp_rdy) begin n_fail++; $display("FAIL coll_late_clear: got %b expected %b", bus.rdy, exp_rdy); end
            end
        join
        wait_neg(2);
        n_cmp++; if (n_ovr !== exp_ovr) begin n_fail++; $display("FAIL coll_ovr: got %0d expected %0d", n_ovr, exp_ovr); end
    endtask

    task automatic test_reset_mid;
        int r0;
        r0 = n_rise;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                wait_neg(5 * D + D / 2);
                rst = 1'b1;
                wait_neg(2);
                rst = 1'b0;
            end
        join
        exp_data = 8'h00;
        exp_rdy  = 1'b0;
        wait_neg(D);
        n_cmp++; if (n_rise !== r0) begin n_fail++; $display("FAIL rstmid_rises: got %0d expected %0d", n_rise, r0); end
        n_cmp++; if (n_frm !== exp_frm) begin n_fail++; $display("FAIL rstmid_frm: got %0d expected %0d", n_frm, exp_frm); end
        n_cmp++; if (n_ovr !== exp_ovr) begin n_fail++; $display("FAIL rstmid_ovr: got %0d expected %0d", n_ovr, exp_ovr); end
        n_cmp++; if (bus.rx_data !== exp_data) begin n_fail++; $display("FAIL rstmid_data: got %h expected %h", bus.rx_data, exp_data); end
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1, 1'b0);
        wait_neg(2);
        n_cmp++; if (bus.rx_data !== exp_data) begin n_fail++; $display("FAIL rstmid_next_data: got %h expected %h", bus.rx_data, exp_data); end
        n_cmp++; if (rise_cyc - fall_cyc !== LAT) begin n_fail++; $display("FAIL rstmid_latency: got %0d expected %0d", rise_cyc - fall_cyc, LAT); end
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic stop, was;
        int r0, gap;
        for (int i = 0; i < 12; i++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(3) != 0);
            if ($urandom_range(1) == 1) clear_rdy();
            was = exp_rdy;
            r0  = n_rise;
            send_frame(d, stop);
            model_frame(d, stop, 1'b0);
            gap = stop ? int'($urandom_range(4)) : 2 + int'($urandom_range(4));
            wait_neg(gap);
            n_cmp++; if (bus.rx_data !== exp_data) begin n_fail++; $display("FAIL rand%0d_data: got %h expected %h", i, bus.rx_data, exp_data); end
            n_cmp++; if (bus.rdy !== exp_rdy) begin n_fail++; $display("FAIL rand%0d_rdy: got %b expected %b", i, bus.rdy, exp_rdy); end
            n_cmp++; if (n_ovr !== exp_ovr) begin n_fail++; $display("FAIL rand%0d_ovr: got %0d expected %0d", i, n_ovr, exp_ovr); end
            n_cmp++; if (n_frm !== exp_frm) begin n_fail++; $display("FAIL rand%0d_frm: got %0d expected %0d", i, n_frm, exp_frm); end
            if (stop && !was) begin
                n_cmp++; if (n_rise !== r0 + 1 || rise_cyc - fall_cyc !== LAT) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, rise_cyc - fall_cyc, LAT); end
            end
        end
    endtask

    initial begin
        bus.RX      = 1'b1;
        bus.clr_rdy = 1'b0;
        wait_neg(1);
        test_reset();
        test_basic();
        test_false_start();
        test_framing();
        test_break();
        test_back_to_back();
        test_clr_collision();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
